// File: rtl/program_sequencer.sv
// program_sequencer: boot and run controller for the single-cycle core.
// Streams a program image into instruction memory, then releases the core and watches for halt/fault.
module program_sequencer #(
    parameter int          MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [15:0] load_count,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        run_pause,
    input  logic [1:0]  decode_error,
    output logic        core_reset,
    output logic        instruction_memory_en,
    output logic        prog_we,
    output logic [31:0] prog_a,
    output logic [31:0] prog_v,
    output logic [2:0]  state,
    output logic [1:0]  fault_code,
    output logic [31:0] cycle_count
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    logic [2:0]  r_state, w_next;
    logic [15:0] r_idx, r_count;
    logic        r_flush, r_load_ready, r_core_reset, r_prog_we;
    logic [31:0] r_prog_a, r_prog_v, r_cycles;
    logic [1:0]  r_fault;
    logic        w_start_ok, w_too_long, w_xfer, w_last, w_step, w_halt, w_err;
    logic        w_load_ready_d, w_core_reset_d;

    assign w_start_ok = start & (r_state == S_IDLE || r_state == S_HALT || r_state == S_FAULT);
    assign w_too_long = {16'd0, load_count} > 32'(MAX_WORDS);
    assign w_xfer     = (r_state == S_LOAD) & load_valid & r_load_ready;
    assign w_last     = r_idx == r_count - 16'd1;
    assign w_step     = (r_state == S_RUN) & ~run_pause;
    assign w_halt     = w_step & (decode_error == 2'b01);
    assign w_err      = w_step & decode_error[1];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_HALT, S_FAULT:
                if (start) w_next = w_too_long ? S_FAULT : (load_count == 16'd0 ? S_FLUSH : S_LOAD);
            S_LOAD:  w_next = (w_xfer && w_last) ? S_FLUSH : S_LOAD;
            S_FLUSH: w_next = r_flush ? S_RUN : S_FLUSH;
            S_RUN:   w_next = w_err ? S_FAULT : (w_halt ? S_HALT : S_RUN);
            default: w_next = S_IDLE;
        endcase
    end

    // HALT/FAULT keep whatever reset level the core had, so a core that ran stays observable
    always_comb begin
        instruction_memory_en = (r_state == S_RUN) & ~run_pause;
        w_load_ready_d        = w_next == S_LOAD;
        w_core_reset_d        = (w_next == S_RUN) ? 1'b0 :
                                (w_next == S_HALT || w_next == S_FAULT) ? r_core_reset : 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_count      <= '0;
            r_flush      <= 1'b0;
            r_load_ready <= 1'b0;
            r_core_reset <= 1'b1;
            r_prog_we    <= 1'b0;
            r_prog_a     <= '0;
            r_prog_v     <= '0;
            r_cycles     <= '0;
            r_fault      <= '0;
        end else begin
            r_state      <= w_next;
            r_load_ready <= w_load_ready_d;
            r_core_reset <= w_core_reset_d;
            r_prog_we    <= w_xfer;
            r_flush      <= (r_state == S_FLUSH) & ~r_flush;
            if (w_start_ok && !w_too_long) begin
                r_idx    <= '0;
                r_count  <= load_count;
                r_cycles <= '0;
                r_fault  <= 2'b00;
            end
            if (w_start_ok && w_too_long) r_fault <= 2'b11;
            if (w_xfer) begin
                r_prog_a <= BASE_ADDR + {14'd0, r_idx, 2'b00};
                r_prog_v <= load_data;
                r_idx    <= r_idx + 16'd1;
            end
            if (w_step && r_cycles != 32'hFFFF_FFFF) r_cycles <= r_cycles + 32'd1;
            if (w_err) r_fault <= 2'b10;
        end
    end

    assign load_ready  = r_load_ready;
    assign core_reset  = r_core_reset;
    assign prog_we     = r_prog_we;
    assign prog_a      = r_prog_a;
    assign prog_v      = r_prog_v;
    assign state       = r_state;
    assign fault_code  = r_fault;
    assign cycle_count = r_cycles;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed sequence with randomized data, stalls and pauses,
// checked against a transaction-level model of load addresses, state timeline and cycle count.
module tb_program_sequencer;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] IDLE = 0, LOAD = 1, FLUSH = 2, RUN = 3, HALT = 4, FAULT = 5;

    logic        Clk = 1'b0, Reset = 1'b1, start = 1'b0, load_valid = 1'b0, run_pause = 1'b0;
    logic [15:0] load_count = '0;
    logic [31:0] load_data = '0;
    logic [1:0]  decode_error = '0;
    logic        load_ready, core_reset, instruction_memory_en, prog_we;
    logic [31:0] prog_a, prog_v, cycle_count;
    logic [2:0]  state;
    logic [1:0]  fault_code;

    int          checks = 0, failures = 0, nwrites = 0;
    logic [31:0] model_cycles = '0;
    bit          pat[$];

    program_sequencer dut (
        .Clk(Clk), .Reset(Reset), .start(start), .load_count(load_count),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .run_pause(run_pause), .decode_error(decode_error), .core_reset(core_reset),
        .instruction_memory_en(instruction_memory_en), .prog_we(prog_we),
        .prog_a(prog_a), .prog_v(prog_v), .state(state), .fault_code(fault_code),
        .cycle_count(cycle_count)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (prog_we === 1'b1) nwrites++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start a load of n words; valid pattern comes from pat, else random with stall_pct idle chance.
    task automatic do_load(input int n, input int stall_pct, input bit fixed, input logic hold);
        logic [31:0] w;
        bit          v;
        int          acc;
        acc = 0;
        nwrites = 0;
        model_cycles = '0;
        load_count = 16'(n);
        start = 1'b1;
        tick();
        start = hold;
        load_count = 16'($urandom_range(1, 300));
        chk("load_state", state, LOAD);
        chk("load_ready", load_ready, 1);
        chk("load_core_reset", core_reset, 1);
        chk("load_cycles_clr", cycle_count, 0);
        while (acc < n) begin
            v = pat.size() > 0 ? pat.pop_front() : ($urandom_range(99) >= stall_pct);
            w = fixed ? 32'hA0 + 32'(acc) : $urandom;
            load_valid = v;
            load_data = w;
            tick();
            if (v) begin
                chk("wr_we", prog_we, 1);
                chk("wr_addr", prog_a, BASE + 32'(4 * acc));
                chk("wr_data", prog_v, w);
                acc++;
            end else begin
                chk("gap_we", prog_we, 0);
            end
            chk("ld_state", state, acc < n ? LOAD : FLUSH);
        end
        load_valid = 1'b0;
        chk("flush_ready", load_ready, 0);
        tick();
        chk("flush2_state", state, FLUSH);
        chk("flush2_we", prog_we, 0);
        chk("flush2_core_reset", core_reset, 1);
        chk("flush2_fetch", instruction_memory_en, 0);
        tick();
        chk("run_state", state, RUN);
        chk("run_core_reset", core_reset, 0);
        chk("write_count", nwrites, n);
    endtask

    task automatic do_run(input int steps, input int pause_pct, input logic hold);
        bit p;
        for (int i = 0; i < steps; i++) begin
            p = pat.size() > 0 ? pat.pop_front() : ($urandom_range(99) < pause_pct);
            run_pause = p;
            decode_error = p ? 2'($urandom_range(1, 3)) : 2'b00;
            start = hold;
            #1;
            chk("run_fetch", instruction_memory_en, !p);
            tick();
            if (!p) model_cycles++;
            chk("run_stay", state, RUN);
        end
        run_pause = 1'b0;
        decode_error = 2'b00;
    endtask

    task automatic finish_run(input logic [1:0] err);
        logic [31:0] s;
        s = err == 2'b01 ? HALT : FAULT;
        start = 1'b0;
        run_pause = 1'b0;
        decode_error = err;
        tick();
        decode_error = 2'b00;
        model_cycles++;
        chk("end_state", state, s);
        chk("end_cycles", cycle_count, model_cycles);
        chk("end_fetch", instruction_memory_en, 0);
        chk("end_core_reset", core_reset, 0);
        if (err[1]) chk("end_fault", fault_code, 2'b10);
        repeat (2) tick();
        chk("frozen_state", state, s);
        chk("frozen_cycles", cycle_count, model_cycles);
        chk("frozen_fetch", instruction_memory_en, 0);
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        chk("rst_state", state, IDLE);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_fetch", instruction_memory_en, 0);
        chk("rst_ready", load_ready, 0);
        chk("rst_we", prog_we, 0);
        chk("rst_a", prog_a, 0);
        chk("rst_v", prog_v, 0);
        chk("rst_fault", fault_code, 0);
        chk("rst_cycles", cycle_count, 0);
        tick();
        chk("idle_stay", state, IDLE);

        // four words back to back with start held (ignored), then halt after 2 paused + 10 run cycles
        do_load(4, 0, 1'b1, 1'b1);
        pat = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        do_run(12, 0, 1'b1);
        finish_run(2'b01);
        chk("halt_cycles_11", cycle_count, 11);

        // restart from HALT with a stalled three-word stream
        pat = '{1, 0, 0, 1, 1};
        do_load(3, 0, 1'b0, 1'b0);

        // random run ending in a core error, start held high throughout
        do_run(20, 40, 1'b1);
        finish_run(2'b10);

        // oversize program
        nwrites = 0;
        load_count = 16'd257;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len_state", state, FAULT);
        chk("len_fault", fault_code, 2'b11);
        repeat (3) tick();
        chk("len_no_write", nwrites, 0);

        for (int k = 0; k < 3; k++) begin
            do_load($urandom_range(1, 8), 30, 1'b0, 1'(k));
            do_run($urandom_range(5, 25), 30, 1'b0);
            finish_run(k == 1 ? 2'b11 : 2'b01);
        end

        // empty program goes straight through FLUSH
        nwrites = 0;
        load_count = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_flush", state, FLUSH);
        chk("zero_core_reset", core_reset, 1);
        tick();
        chk("zero_flush2", state, FLUSH);
        tick();
        chk("zero_run", state, RUN);
        chk("zero_no_write", nwrites, 0);
        model_cycles = '0;
        finish_run(2'b01);

        // largest legal length, then asynchronous reset mid-cycle with a write pending
        load_count = 16'd256;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("max_state", state, LOAD);
        load_valid = 1'b1;
        load_data = $urandom;
        repeat (2) tick();
        chk("pre_rst_we", prog_we, 1);
        #3;
        Reset = 1'b1;
        #1;
        chk("arst_state", state, IDLE);
        chk("arst_core_reset", core_reset, 1);
        chk("arst_we", prog_we, 0);
        chk("arst_ready", load_ready, 0);
        chk("arst_a", prog_a, 0);
        chk("arst_v", prog_v, 0);
        chk("arst_fault", fault_code, 0);
        chk("arst_cycles", cycle_count, 0);
        chk("arst_fetch", instruction_memory_en, 0);
        load_valid = 1'b0;
        tick();
        Reset = 1'b0;
        tick();
        chk("post_rst_state", state, IDLE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
